// File: rtl/pw_burst_sequencer_if.sv
// Control-bank and pin-side signals of the pulsed-wave burst sequencer.
// The sequencer takes the slave view; the register bank / bench drives the master view.
interface pw_burst_sequencer_if #(
    parameter int CYC_W = 6,
    parameter int DLY_W = 12,
    parameter int PRF_W = 16
);
    logic             enable;
    logic [1:0]       freqSel;
    logic [CYC_W-1:0] numCycles;
    logic [DLY_W-1:0] gateDelay;
    logic [DLY_W-1:0] gateLen;
    logic [PRF_W-1:0] prfPeriod;

    logic             burstPos;
    logic             burstNeg;
    logic             txPwdn;
    logic             rxPwdn;
    logic             rxGate;
    logic             sampleStrobe;
    logic             prfTick;
    logic             overrun;

    modport master (
        output enable, freqSel, numCycles, gateDelay, gateLen, prfPeriod,
        input  burstPos, burstNeg, txPwdn, rxPwdn, rxGate, sampleStrobe, prfTick, overrun
    );

    modport slave (
        input  enable, freqSel, numCycles, gateDelay, gateLen, prfPeriod,
        output burstPos, burstNeg, txPwdn, rxPwdn, rxGate, sampleStrobe, prfTick, overrun
    );
endinterface

// File: rtl/pw_burst_sequencer.sv
// Pulsed-wave Doppler period sequencer: bipolar TX burst, range-gate delay,
// receive window with decimated ADC strobes, then hold until the PRF period ends.
//
// state | meaning
// IDLE  | not sequencing, waiting for enable
// TX    | bipolar burst, numCycles full cycles of H clocks pos + H clocks neg
// WAIT  | range-gate delay after the burst, receiver powered
// RX    | receive window open, sample strobes every DECIM clocks
// HOLD  | all activity done, waiting out the remainder of the PRF period
module pw_burst_sequencer #(
    parameter int HALF8 = 4,
    parameter int CYC_W = 6,
    parameter int DLY_W = 12,
    parameter int PRF_W = 16,
    parameter int DECIM = 4
) (
    input logic            clk,
    input logic            rst,
    pw_burst_sequencer_if.slave bus
);
    localparam int HW = $clog2(8 * HALF8) + 1;
    localparam int DW = $clog2(DECIM) + 1;

    typedef enum logic [2:0] {IDLE, TX, WAIT, RX, HOLD} stateT;

    stateT            state, stateNext;
    logic [PRF_W-1:0] periodCnt, periodNext;
    logic [DLY_W-1:0] phaseCnt, phaseNext;
    logic [HW-1:0]    halfCnt, halfNext;
    logic             pol, polNext;
    logic [CYC_W-1:0] cycLeft, cycNext;
    logic [DW-1:0]    decimCnt, decimNext;
    logic             stopReq, stopNext;

    // Per-period configuration, captured on the prfTick clock.
    logic [HW-1:0]    cfgHalf;
    logic [DLY_W-1:0] cfgDelay, cfgLen;
    logic [PRF_W-1:0] cfgLast;

    logic [HW-1:0]    inHalf;
    logic [PRF_W-1:0] inLast;
    logic [DLY_W-1:0] eDelay, eLen;
    logic [PRF_W-1:0] eLast;

    logic start, leaveTx, leaveWait, leaveRx, endAct, lastNext;

    logic burstPosQ, burstNegQ, txPwdnQ, rxPwdnQ, rxGateQ, strobeQ, prfTickQ, overrunQ;
    logic burstPosD, burstNegD, txPwdnD, rxPwdnD, rxGateD, strobeD, prfTickD, overrunD;

    assign inHalf = (bus.freqSel == 2'b11) ? HW'(HALF8)     :
                    (bus.freqSel == 2'b10) ? HW'(2 * HALF8) :
                    (bus.freqSel == 2'b01) ? HW'(4 * HALF8) : HW'(8 * HALF8);

    // prfPeriod of 0 behaves as 1, so the last period clock index is 0 either way.
    assign inLast = (bus.prfPeriod == '0) ? '0 : bus.prfPeriod - PRF_W'(1);

    // Next state, counter updates and the registered output values for the coming clock.
    always_comb begin
        stateNext  = state;
        periodNext = (periodCnt == '1) ? periodCnt : periodCnt + PRF_W'(1);
        phaseNext  = phaseCnt;
        halfNext   = halfCnt;
        polNext    = pol;
        cycNext    = cycLeft;
        decimNext  = decimCnt;
        stopNext   = stopReq;
        start      = 1'b0;
        leaveTx    = 1'b0;
        leaveWait  = 1'b0;
        leaveRx    = 1'b0;
        endAct     = 1'b0;

        case (state)
            IDLE: start = bus.enable;
            TX: begin
                // A stop request is honoured only at a full-cycle boundary to avoid DC on the pulser.
                if (!bus.enable) stopNext = 1'b1;
                if (halfCnt != '0) begin
                    halfNext = halfCnt - HW'(1);
                end else if (!pol) begin
                    polNext  = 1'b1;
                    halfNext = cfgHalf - HW'(1);
                end else if (stopReq || !bus.enable) begin
                    stateNext = IDLE;
                end else if (cycLeft > CYC_W'(1)) begin
                    cycNext  = cycLeft - CYC_W'(1);
                    polNext  = 1'b0;
                    halfNext = cfgHalf - HW'(1);
                end else begin
                    leaveTx = 1'b1;
                end
            end
            WAIT: begin
                if (!bus.enable)           stateNext = IDLE;
                else if (phaseCnt != '0)   phaseNext = phaseCnt - DLY_W'(1);
                else                       leaveWait = 1'b1;
            end
            RX: begin
                if (!bus.enable) begin
                    stateNext = IDLE;
                end else begin
                    decimNext = (decimCnt == '0) ? DW'(DECIM - 1) : decimCnt - DW'(1);
                    if (phaseCnt != '0) phaseNext = phaseCnt - DLY_W'(1);
                    else                leaveRx   = 1'b1;
                end
            end
            HOLD: begin
                if (!bus.enable)                 stateNext = IDLE;
                else if (periodCnt >= cfgLast)   start     = 1'b1;
            end
            default: stateNext = IDLE;
        endcase

        if (leaveTx) begin
            if (cfgDelay != '0) begin
                stateNext = WAIT;
                phaseNext = cfgDelay - DLY_W'(1);
            end else if (cfgLen != '0) begin
                stateNext = RX;
                phaseNext = cfgLen - DLY_W'(1);
                decimNext = DW'(DECIM - 1);
            end else begin
                endAct = 1'b1;
            end
        end

        if (leaveWait) begin
            if (cfgLen != '0) begin
                stateNext = RX;
                phaseNext = cfgLen - DLY_W'(1);
                decimNext = DW'(DECIM - 1);
            end else begin
                endAct = 1'b1;
            end
        end

        if (leaveRx) endAct = 1'b1;

        // Running late skips HOLD and starts the next period back-to-back.
        if (endAct) begin
            if (periodCnt >= cfgLast) start     = 1'b1;
            else                      stateNext = HOLD;
        end

        // New period: the first non-empty phase starts on the prfTick clock.
        if (start) begin
            periodNext = '0;
            stopNext   = 1'b0;
            if (bus.numCycles != '0) begin
                stateNext = TX;
                halfNext  = inHalf - HW'(1);
                polNext   = 1'b0;
                cycNext   = bus.numCycles;
            end else if (bus.gateDelay != '0) begin
                stateNext = WAIT;
                phaseNext = bus.gateDelay - DLY_W'(1);
            end else if (bus.gateLen != '0) begin
                stateNext = RX;
                phaseNext = bus.gateLen - DLY_W'(1);
                decimNext = DW'(DECIM - 1);
            end else begin
                stateNext = HOLD;
            end
        end

        eDelay = start ? bus.gateDelay : cfgDelay;
        eLen   = start ? bus.gateLen   : cfgLen;
        eLast  = start ? inLast        : cfgLast;

        // Whether the coming clock is the final clock of the period's active phases.
        lastNext = ((stateNext == RX) && (phaseNext == '0)) ||
                   ((stateNext == WAIT) && (phaseNext == '0) && (eLen == '0)) ||
                   ((stateNext == TX) && (halfNext == '0) && polNext && (cycNext == CYC_W'(1)) &&
                    (eDelay == '0) && (eLen == '0));

        prfTickD  = start;
        burstPosD = (stateNext == TX) && !polNext;
        burstNegD = (stateNext == TX) && polNext;
        txPwdnD   = (stateNext != TX);
        rxGateD   = (stateNext == RX);
        strobeD   = (stateNext == RX) && (decimNext == DW'(DECIM - 1));
        overrunD  = lastNext && (periodNext >= eLast);
        // After an abort the receiver stays powered for one extra IDLE clock.
        rxPwdnD   = !((stateNext == WAIT) || (stateNext == RX) ||
                      ((stateNext == IDLE) && ((state == WAIT) || (state == RX))));
    end

    // State, counters, captured configuration and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            periodCnt <= '0;
            phaseCnt  <= '0;
            halfCnt   <= '0;
            pol       <= 1'b0;
            cycLeft   <= '0;
            decimCnt  <= '0;
            stopReq   <= 1'b0;
            cfgHalf   <= '0;
            cfgDelay  <= '0;
            cfgLen    <= '0;
            cfgLast   <= '0;
            burstPosQ <= 1'b0;
            burstNegQ <= 1'b0;
            txPwdnQ   <= 1'b1;
            rxPwdnQ   <= 1'b1;
            rxGateQ   <= 1'b0;
            strobeQ   <= 1'b0;
            prfTickQ  <= 1'b0;
            overrunQ  <= 1'b0;
        end else begin
            state     <= stateNext;
            periodCnt <= periodNext;
            phaseCnt  <= phaseNext;
            halfCnt   <= halfNext;
            pol       <= polNext;
            cycLeft   <= cycNext;
            decimCnt  <= decimNext;
            stopReq   <= stopNext;
            if (start) begin
                cfgHalf  <= inHalf;
                cfgDelay <= bus.gateDelay;
                cfgLen   <= bus.gateLen;
                cfgLast  <= inLast;
            end
            burstPosQ <= burstPosD;
            burstNegQ <= burstNegD;
            txPwdnQ   <= txPwdnD;
            rxPwdnQ   <= rxPwdnD;
            rxGateQ   <= rxGateD;
            strobeQ   <= strobeD;
            prfTickQ  <= prfTickD;
            overrunQ  <= overrunD;
        end
    end

    assign bus.burstPos     = burstPosQ;
    assign bus.burstNeg     = burstNegQ;
    assign bus.txPwdn       = txPwdnQ;
    assign bus.rxPwdn       = rxPwdnQ;
    assign bus.rxGate       = rxGateQ;
    assign bus.sampleStrobe = strobeQ;
    assign bus.prfTick      = prfTickQ;
    assign bus.overrun      = overrunQ;
endmodule

// File: tb/tb_pw_burst_sequencer.sv
// Bench for pw_burst_sequencer: table of period configurations plus hand-written
// abort / reset / frequency-step sequences. Output bits are packed as
// {prfTick, burstPos, burstNeg, txPwdn, rxPwdn, rxGate, sampleStrobe, overrun}.
module tb_pw_burst_sequencer;
    localparam int HALF8 = 4;
    localparam int DECIM = 4;
    localparam logic [7:0] IDLE_OUT = 8'b0001_1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pw_burst_sequencer_if #(.CYC_W(6), .DLY_W(12), .PRF_W(16)) bus();

    pw_burst_sequencer #(
        .HALF8(HALF8), .CYC_W(6), .DLY_W(12), .PRF_W(16), .DECIM(DECIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int fs;
        int n;
        int d;
        int l;
        int p;
        int expPer;
        int expOvAt;
    } vecT;

    vecT        vecs[6];
    logic [7:0] sbQ[$];
    int         numChecks = 0;
    int         numFails  = 0;

    function automatic logic [7:0] sampleOut();
        return {bus.prfTick, bus.burstPos, bus.burstNeg, bus.txPwdn,
                bus.rxPwdn, bus.rxGate, bus.sampleStrobe, bus.overrun};
    endfunction

    // Expected outputs at clock k of a period, written from the period timeline.
    function automatic logic [7:0] expAt(int fs, int n, int d, int l, int p, int k);
        int h, t, act, pe;
        logic pt, pos, neg, txp, rxp, gate, stb, ov;
        h    = HALF8 << (3 - fs);
        t    = 2 * h * n;
        act  = t + d + l;
        pe   = (p == 0) ? 1 : p;
        pt   = (k == 0);
        pos  = (k < t) && (((k / h) % 2) == 0);
        neg  = (k < t) && (((k / h) % 2) == 1);
        txp  = !(k < t);
        rxp  = !((k >= t) && (k < act));
        gate = (k >= t + d) && (k < act);
        stb  = gate && (((k - t - d) % DECIM) == 0);
        ov   = (act > 0) && (k == act - 1) && (act >= pe);
        return {pt, pos, neg, txp, rxp, gate, stb, ov};
    endfunction

    task automatic checkVal(input string tag, input int k, input logic [7:0] got, input logic [7:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s k=%0d got=%b want=%b", tag, k, got, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int got, input int exp);
        numChecks++;
        if (got != exp) begin
            numFails++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic stepCheck(input string tag, input int k, input logic [7:0] exp, output logic [7:0] got);
        sbQ.push_back(exp);
        @(negedge clk);
        got = sampleOut();
        checkVal(tag, k, got, sbQ.pop_front());
    endtask

    task automatic setCfg(input int fs, input int n, input int d, input int l, input int p);
        bus.freqSel   = fs[1:0];
        bus.numCycles = n[5:0];
        bus.gateDelay = d[11:0];
        bus.gateLen   = l[11:0];
        bus.prfPeriod = p[15:0];
    endtask

    // Raise enable; the following edge samples it, so clock 0 of the period comes next.
    task automatic startRun();
        @(posedge clk);
        #1 bus.enable = 1'b1;
        @(posedge clk);
    endtask

    task automatic stopRun(input string tag);
        bus.enable = 1'b0;
        repeat (80) @(negedge clk);
        checkVal(tag, 0, sampleOut(), IDLE_OUT);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        int         secondTick, ovAt, per, h, act;
        int         fsList[4];

        vecs[0] = '{3, 3, 10, 16, 100, 100, -1};
        vecs[1] = '{3, 3, 10, 16,  40,  50, 49};
        vecs[2] = '{3, 0,  0,  5,  20,  20, -1};
        vecs[3] = '{2, 2,  0,  3,   0,  35, 34};
        vecs[4] = '{1, 1,  5,  0,  60,  60, -1};
        vecs[5] = '{0, 1,  0,  9,  90,  90, -1};
        fsList  = '{3, 2, 1, 0};

        bus.enable = 1'b0;
        setCfg(3, 3, 10, 16, 100);

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #2 checkVal("resetAsync", 0, sampleOut(), IDLE_OUT);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 3; k++) stepCheck("idleNoEnable", k, IDLE_OUT, got);

        // Table of period configurations, two full periods each.
        for (int v = 0; v < 6; v++) begin
            setCfg(vecs[v].fs, vecs[v].n, vecs[v].d, vecs[v].l, vecs[v].p);
            startRun();
            secondTick = -1;
            ovAt       = -1;
            per        = vecs[v].expPer;
            for (int k = 0; k <= 2 * per; k++) begin
                stepCheck($sformatf("vec%0d", v), k,
                          expAt(vecs[v].fs, vecs[v].n, vecs[v].d, vecs[v].l, vecs[v].p, k % per), got);
                if (k > 0 && got[7] && secondTick < 0) secondTick = k;
                if (got[0] && ovAt < 0) ovAt = k;
            end
            checkInt($sformatf("vec%0d_period", v), secondTick, vecs[v].expPer);
            checkInt($sformatf("vec%0d_overrunAt", v), ovAt, vecs[v].expOvAt);
            stopRun($sformatf("vec%0d_idle", v));
        end

        // freqSel stepped between periods; each period uses the value latched at its prfTick.
        setCfg(3, 3, 10, 16, 100);
        startRun();
        for (int i = 0; i < 4; i++) begin
            h   = HALF8 << (3 - fsList[i]);
            act = 2 * h * 3 + 26;
            per = (act > 100) ? act : 100;
            for (int k = 0; k < per; k++) begin
                stepCheck($sformatf("freqStep%0d", i), k, expAt(fsList[i], 3, 10, 16, 100, k), got);
                if (k == 5 && i < 3) bus.freqSel = fsList[i + 1][1:0];
            end
        end
        stopRun("freqStepIdle");

        // enable dropped during TX clock 9: cycle 2 completes, then idle with no prfTick.
        setCfg(3, 3, 10, 16, 100);
        startRun();
        for (int k = 0; k <= 40; k++) begin
            stepCheck("txAbort", k, (k < 16) ? expAt(3, 3, 10, 16, 100, k) : IDLE_OUT, got);
            if (k == 9) bus.enable = 1'b0;
        end

        // enable dropped during RX clock 3: gate drops next clock, rxPwdn one clock later.
        startRun();
        for (int k = 0; k <= 45; k++) begin
            stepCheck("rxAbort", k,
                      (k <= 37) ? expAt(3, 3, 10, 16, 100, k) :
                      (k == 38) ? 8'b0001_0000 : IDLE_OUT, got);
            if (k == 37) bus.enable = 1'b0;
        end

        // rst asserted during RX clock 3, between clock edges.
        startRun();
        for (int k = 0; k <= 37; k++) stepCheck("preReset", k, expAt(3, 3, 10, 16, 100, k), got);
        #2 rst = 1'b1;
        #1 checkVal("resetMidRx", 37, sampleOut(), IDLE_OUT);
        repeat (2) @(negedge clk);
        checkVal("resetHeld", 0, sampleOut(), IDLE_OUT);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) stepCheck("afterReset", k, expAt(3, 3, 10, 16, 100, k), got);
        stopRun("finalIdle");

        if (sbQ.size() != 0) begin
            numFails++;
            $display("FAIL scoreboard leftover entries=%0d", sbQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule

// File: doc/pw_burst_sequencer.md
Name: pw_burst_sequencer

Overview:
- Parametrised successor to the fixed transmitter/receiver pair: one block sequences a complete pulsed-wave Doppler period.
- Each period runs a bipolar transmit burst, then a programmable range-gate delay, then a receive/sample window with a sample strobe for the ADC front end, then waits out the PRF period.
- Sits between the control register bank and the pulser/ADC pins. Adds 1 MHz mode, programmable cycle count, range gating, decimated strobes and PRF overrun detection.

Parameters:
- HALF8, 4: clocks per half-period at 8 MHz (64 MHz clk); must be ≥1.
- CYC_W, 6: width of numCycles.
- DLY_W, 12: width of gateDelay and gateLen.
- PRF_W, 16: width of prfPeriod and the period counter.
- DECIM, 4: clocks between sampleStrobe pulses inside the gate; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  run sequencing while high
- freqSel  in  2  11=8 MHz, 10=4 MHz, 01=2 MHz, 00=1 MHz
- numCycles  in  CYC_W  burst cycles per period
- gateDelay  in  DLY_W  clocks from burst end to gate open
- gateLen  in  DLY_W  gate length in clocks
- prfPeriod  in  PRF_W  period length in clocks
- burstPos  out  1  positive pulser drive
- burstNeg  out  1  negative pulser drive
- txPwdn  out  1  transmitter power-down, active high
- rxPwdn  out  1  receiver/ADC power-down, active high
- rxGate  out  1  receive window active
- sampleStrobe  out  1  one-clock ADC sample pulse
- prfTick  out  1  one-clock pulse on the first clock of each period
- overrun  out  1  one-clock pulse when a period exceeds prfPeriod

Behaviour:
- Reset values (asynchronous): outputs burstPos, burstNeg, rxGate, sampleStrobe, prfTick and overrun are 0; txPwdn and rxPwdn are 1. Internal state is IDLE and all counters are 0.
- States: IDLE, TX, WAIT, RX, HOLD. All outputs are registered.
- Config latch: freqSel, numCycles, gateDelay, gateLen and prfPeriod are latched on entry to TX, i.e. the clock on which prfTick is asserted. Input changes mid-period take effect in the next period.
- Half-period H in clocks: HALF8 for 11, 2·HALF8 for 10, 4·HALF8 for 01, 8·HALF8 for 00.
- IDLE -> TX: when enable=1 is sampled in IDLE, the next clock is TX clock 0. On that clock prfTick=1, burstPos=1 and periodCnt=0.
- periodCnt increments every clock from TX entry. It saturates at all-ones.
- TX waveform:
  - Each cycle is H clocks of burstPos=1, then H clocks of burstNeg=1.
  - burstPos and burstNeg are never both 1.
  - TX lasts exactly 2·H·numCycles clocks.
  - txPwdn=0 throughout TX, 1 in every other state.
- numCycles=0: no burst and no TX clocks. prfTick still pulses, coincident with the first WAIT clock.
- WAIT lasts gateDelay clocks; 0 means RX follows TX directly.
- rxPwdn=0 from the first WAIT clock through the last RX clock, 1 otherwise.
- RX:
  - rxGate=1 for exactly gateLen clocks.
  - sampleStrobe=1 on RX clock 0 and on every DECIM-th clock after it, inside the gate only.
  - gateLen=0 skips RX: no rxGate, no strobes.
- HOLD: the next TX begins on the clock after periodCnt = prfPeriod−1. Period length is therefore max(prfPeriod, TX+WAIT+RX) clocks.
- Overrun: if RX (or the last active state) ends with periodCnt ≥ prfPeriod−1, then overrun=1 for one clock and the next TX starts on the immediately following clock. HOLD is skipped.
- prfPeriod=0 is treated as 1 (always overrun if any state is active).
- enable falls during TX: the current full cycle (pos+neg half) completes, then the block goes to IDLE. No partial cycle, no DC residue.
- enable falls during WAIT, RX or HOLD: the block goes to IDLE on the next clock. rxGate and strobes drop immediately; rxPwdn returns to 1 one clock later.
- enable=1 at the end of HOLD: next period. enable=0 at the end of HOLD: IDLE.
- rst mid-operation: all outputs go to reset values asynchronously. After rst deassert, the block waits in IDLE for enable.

Test Plan:
- HALF8=4, freqSel=11, numCycles=3, gateDelay=10, gateLen=16, prfPeriod=100, DECIM=4 -> relative to prfTick:
  - burstPos at clocks 0–3, 8–11, 16–19; burstNeg at 4–7, 12–15, 20–23.
  - rxGate at 34–49; sampleStrobe at 34, 38, 42, 46.
  - prfTick repeats every 100 clocks.
- Same setup with freqSel stepped 11→10→01→00 between periods -> half-periods of 4, 8, 16 and 32 clocks. Each change appears only from the period after the write.
- prfPeriod=40 with the setup above (50 active clocks) -> overrun pulse at clock 49, next prfTick at clock 50, period 50 clocks.
- enable dropped at TX clock 9 (mid positive half of cycle 2) -> burst continues through clock 15, then all outputs idle. No further prfTick.
- numCycles=0, gateDelay=0, gateLen=5 -> no burst; prfTick coincident with rxGate at clocks 0–4; strobes at 0 and 4.
- rst asserted at RX clock 3 -> rxGate, sampleStrobe and burst outputs are 0, and txPwdn and rxPwdn are 1, without waiting for a clk edge. After release with enable=1, the first prfTick arrives one clock after enable is sampled.
